// File: rtl/mem_arbiter.sv
// Single-port 2**ADDR_W x DATA_W memory shared by CPU and debug/loader ports, one access per clock.
// Grant is combinational; read data is registered and valid for one cycle after the grant.
module mem_arbiter #(
  parameter int ADDR_W        = 8,
  parameter int DATA_W        = 8,
  parameter int PRIORITY_MODE = 0
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              cpu_req,
  input  logic              cpu_we,
  input  logic [ADDR_W-1:0] cpu_addr,
  input  logic [DATA_W-1:0] cpu_wdata,
  output logic              cpu_gnt,
  output logic              cpu_rvalid,
  output logic [DATA_W-1:0] cpu_rdata,
  input  logic              dbg_req,
  input  logic              dbg_we,
  input  logic [ADDR_W-1:0] dbg_addr,
  input  logic [DATA_W-1:0] dbg_wdata,
  input  logic              dbg_lock,
  output logic              dbg_gnt,
  output logic              dbg_rvalid,
  output logic [DATA_W-1:0] dbg_rdata,
  output logic              locked
);

  localparam int DEPTH = 1 << ADDR_W;

  typedef enum logic {UNLOCKED = 1'b0, LOCKED = 1'b1} lock_state_e;

  lock_state_e       state_q, state_d;
  logic              last_dbg_q, last_dbg_d;
  logic              cpu_rvalid_q, cpu_rvalid_d;
  logic              dbg_rvalid_q, dbg_rvalid_d;
  logic [DATA_W-1:0] cpu_rdata_q, cpu_rdata_d;
  logic [DATA_W-1:0] dbg_rdata_q, dbg_rdata_d;
  logic [DATA_W-1:0] mem_q [DEPTH];

  // State register: lock FSM, round-robin pointer and read-return flops.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q      <= UNLOCKED;
      last_dbg_q   <= 1'b1;
      cpu_rvalid_q <= 1'b0;
      dbg_rvalid_q <= 1'b0;
      cpu_rdata_q  <= '0;
      dbg_rdata_q  <= '0;
    end else begin
      state_q      <= state_d;
      last_dbg_q   <= last_dbg_d;
      cpu_rvalid_q <= cpu_rvalid_d;
      dbg_rvalid_q <= dbg_rvalid_d;
      cpu_rdata_q  <= cpu_rdata_d;
      dbg_rdata_q  <= dbg_rdata_d;
    end
  end

  // Memory contents survive reset; grants are already suppressed while in reset.
  always_ff @(posedge clk) begin
    if (cpu_gnt && cpu_we) mem_q[cpu_addr] <= cpu_wdata;
    if (dbg_gnt && dbg_we) mem_q[dbg_addr] <= dbg_wdata;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      UNLOCKED: if (dbg_gnt && dbg_lock) state_d = LOCKED;
      LOCKED:   if (!dbg_lock)           state_d = UNLOCKED;
      default:                           state_d = UNLOCKED;
    endcase
  end

  always_comb begin
    cpu_gnt = 1'b0;
    dbg_gnt = 1'b0;
    if (rst_n) begin
      if (state_q == LOCKED) begin
        dbg_gnt = dbg_req;
      end else if (cpu_req && dbg_req) begin
        // Conflict: fixed priority to dbg, or whichever port was not served last.
        if (PRIORITY_MODE != 0 || !last_dbg_q) dbg_gnt = 1'b1;
        else                                   cpu_gnt = 1'b1;
      end else begin
        cpu_gnt = cpu_req;
        dbg_gnt = dbg_req;
      end
    end
  end

  always_comb begin
    last_dbg_d   = last_dbg_q;
    if (cpu_gnt) last_dbg_d = 1'b0;
    if (dbg_gnt) last_dbg_d = 1'b1;
    cpu_rvalid_d = cpu_gnt && !cpu_we;
    dbg_rvalid_d = dbg_gnt && !dbg_we;
    cpu_rdata_d  = cpu_rvalid_d ? mem_q[cpu_addr] : cpu_rdata_q;
    dbg_rdata_d  = dbg_rvalid_d ? mem_q[dbg_addr] : dbg_rdata_q;
  end

  assign cpu_rvalid = cpu_rvalid_q;
  assign dbg_rvalid = dbg_rvalid_q;
  assign cpu_rdata  = cpu_rdata_q;
  assign dbg_rdata  = dbg_rdata_q;
  assign locked     = (state_q == LOCKED);

endmodule

// File: tb/tb_mem_arbiter.sv
// Directed bench for mem_arbiter: one round-robin instance and one fixed-priority instance
// sharing the same stimulus.
module tb_mem_arbiter;

  logic       clk;
  logic       rst_n;
  logic       cpu_req, cpu_we, dbg_req, dbg_we, dbg_lock;
  logic [7:0] cpu_addr, cpu_wdata, dbg_addr, dbg_wdata;

  logic       cpu_gnt, cpu_rvalid, dbg_gnt, dbg_rvalid, locked;
  logic [7:0] cpu_rdata, dbg_rdata;
  logic       m1_cpu_gnt, m1_cpu_rvalid, m1_dbg_gnt, m1_dbg_rvalid, m1_locked;
  logic [7:0] m1_cpu_rdata, m1_dbg_rdata;

  int total = 0;
  int bad   = 0;

  mem_arbiter #(.ADDR_W(8), .DATA_W(8), .PRIORITY_MODE(0)) dut (
    .clk(clk), .rst_n(rst_n),
    .cpu_req(cpu_req), .cpu_we(cpu_we), .cpu_addr(cpu_addr), .cpu_wdata(cpu_wdata),
    .cpu_gnt(cpu_gnt), .cpu_rvalid(cpu_rvalid), .cpu_rdata(cpu_rdata),
    .dbg_req(dbg_req), .dbg_we(dbg_we), .dbg_addr(dbg_addr), .dbg_wdata(dbg_wdata),
    .dbg_lock(dbg_lock), .dbg_gnt(dbg_gnt), .dbg_rvalid(dbg_rvalid), .dbg_rdata(dbg_rdata),
    .locked(locked)
  );

  mem_arbiter #(.ADDR_W(8), .DATA_W(8), .PRIORITY_MODE(1)) dut_m1 (
    .clk(clk), .rst_n(rst_n),
    .cpu_req(cpu_req), .cpu_we(cpu_we), .cpu_addr(cpu_addr), .cpu_wdata(cpu_wdata),
    .cpu_gnt(m1_cpu_gnt), .cpu_rvalid(m1_cpu_rvalid), .cpu_rdata(m1_cpu_rdata),
    .dbg_req(dbg_req), .dbg_we(dbg_we), .dbg_addr(dbg_addr), .dbg_wdata(dbg_wdata),
    .dbg_lock(dbg_lock), .dbg_gnt(m1_dbg_gnt), .dbg_rvalid(m1_dbg_rvalid),
    .dbg_rdata(m1_dbg_rdata), .locked(m1_locked)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic idle();
    cpu_req = 1'b0; cpu_we = 1'b0; cpu_addr = 8'h00; cpu_wdata = 8'h00;
    dbg_req = 1'b0; dbg_we = 1'b0; dbg_addr = 8'h00; dbg_wdata = 8'h00; dbg_lock = 1'b0;
  endtask

  // Inputs change 1 time unit after a posedge; registered outputs are read at the same point.
  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  initial begin
    // Reset with both requests asserted
    idle();
    rst_n = 1'b0; cpu_req = 1'b1; dbg_req = 1'b1;
    #1;
    check("rst_cpu_gnt", 32'(cpu_gnt), 0);
    check("rst_dbg_gnt", 32'(dbg_gnt), 0);
    check("rst_m1_dbg_gnt", 32'(m1_dbg_gnt), 0);
    cyc(); cyc();
    check("rst_cpu_gnt2", 32'(cpu_gnt), 0);
    check("rst_cpu_rvalid", 32'(cpu_rvalid), 0);
    check("rst_dbg_rvalid", 32'(dbg_rvalid), 0);
    check("rst_cpu_rdata", 32'(cpu_rdata), 0);
    check("rst_dbg_rdata", 32'(dbg_rdata), 0);
    check("rst_locked", 32'(locked), 0);

    // dbg writes, then CPU reads back
    rst_n = 1'b1; idle();
    dbg_req = 1'b1; dbg_we = 1'b1; dbg_addr = 8'h00; dbg_wdata = 8'h0F;
    #1;
    check("wr0_dbg_gnt", 32'(dbg_gnt), 1);
    check("wr0_cpu_gnt", 32'(cpu_gnt), 0);
    cyc();
    check("wr0_no_rvalid", 32'(dbg_rvalid), 0);
    dbg_addr = 8'h01; dbg_wdata = 8'h0E;
    #1;
    check("wr1_dbg_gnt", 32'(dbg_gnt), 1);
    cyc();
    idle();
    cpu_req = 1'b1; cpu_addr = 8'h00;
    #1;
    check("rd0_cpu_gnt", 32'(cpu_gnt), 1);
    cyc();
    check("rd0_rvalid", 32'(cpu_rvalid), 1);
    check("rd0_rdata", 32'(cpu_rdata), 32'h0F);
    cpu_addr = 8'h01;
    cyc();
    check("rd1_rvalid", 32'(cpu_rvalid), 1);
    check("rd1_rdata", 32'(cpu_rdata), 32'h0E);
    idle();
    cyc();
    check("rd_rvalid_drop", 32'(cpu_rvalid), 0);
    check("rd_rdata_hold", 32'(cpu_rdata), 32'h0E);

    // Lone dbg read leaves the round-robin pointer at "dbg last"
    dbg_req = 1'b1; dbg_addr = 8'h01;
    cyc();
    check("dbgrd_rvalid", 32'(dbg_rvalid), 1);
    check("dbgrd_rdata", 32'(dbg_rdata), 32'h0E);
    check("dbgrd_cpu_rvalid", 32'(cpu_rvalid), 0);

    // Round-robin on held conflicting reads
    idle();
    cpu_req = 1'b1; cpu_addr = 8'h00; dbg_req = 1'b1; dbg_addr = 8'h01;
    for (int i = 0; i < 4; i++) begin
      #1;
      check("rr_cpu_gnt", 32'(cpu_gnt), (i % 2 == 0) ? 1 : 0);
      check("rr_dbg_gnt", 32'(dbg_gnt), (i % 2 == 1) ? 1 : 0);
      cyc();
      check("rr_cpu_rvalid", 32'(cpu_rvalid), (i % 2 == 0) ? 1 : 0);
      check("rr_dbg_rvalid", 32'(dbg_rvalid), (i % 2 == 1) ? 1 : 0);
    end
    check("rr_cpu_rdata", 32'(cpu_rdata), 32'h0F);
    check("rr_dbg_rdata", 32'(dbg_rdata), 32'h0E);

    // Locked burst: a lone CPU read first so dbg wins the opening conflict
    idle();
    cpu_req = 1'b1; cpu_addr = 8'h00;
    cyc();
    check("pre_lock_rdata", 32'(cpu_rdata), 32'h0F);
    cpu_addr = 8'h05;
    dbg_req = 1'b1; dbg_we = 1'b1; dbg_lock = 1'b1;
    for (int i = 0; i < 6; i++) begin
      dbg_addr = 8'(i); dbg_wdata = 8'(i);
      #1;
      check("lock_dbg_gnt", 32'(dbg_gnt), 1);
      check("lock_cpu_gnt", 32'(cpu_gnt), 0);
      cyc();
      check("lock_locked", 32'(locked), 1);
    end
    dbg_req = 1'b0; dbg_we = 1'b0; dbg_lock = 1'b0;
    #1;
    check("unlock_cpu_gnt_a", 32'(cpu_gnt), 0);
    check("unlock_dbg_gnt_a", 32'(dbg_gnt), 0);
    cyc();
    check("unlock_locked", 32'(locked), 0);
    #1;
    check("unlock_cpu_gnt_b", 32'(cpu_gnt), 1);
    cyc();
    check("unlock_rvalid", 32'(cpu_rvalid), 1);
    check("unlock_rdata5", 32'(cpu_rdata), 32'h05);
    cpu_addr = 8'h02;
    cyc();
    check("unlock_rdata2", 32'(cpu_rdata), 32'h02);

    // Fixed priority instance: dbg always wins
    idle();
    cpu_req = 1'b1; cpu_addr = 8'h03; dbg_req = 1'b1; dbg_addr = 8'h04;
    for (int i = 0; i < 3; i++) begin
      #1;
      check("m1_dbg_gnt", 32'(m1_dbg_gnt), 1);
      check("m1_cpu_gnt", 32'(m1_cpu_gnt), 0);
      cyc();
      check("m1_dbg_rvalid", 32'(m1_dbg_rvalid), 1);
      check("m1_cpu_rvalid", 32'(m1_cpu_rvalid), 0);
    end
    check("m1_dbg_rdata", 32'(m1_dbg_rdata), 32'h04);

    // Reset clears an in-flight read and the lock
    idle();
    dbg_req = 1'b1; dbg_we = 1'b1; dbg_lock = 1'b1; dbg_addr = 8'h07; dbg_wdata = 8'h77;
    cyc();
    check("r6_locked", 32'(locked), 1);
    dbg_we = 1'b0; dbg_addr = 8'h04;
    cyc();
    check("r6_dbg_rvalid", 32'(dbg_rvalid), 1);
    check("r6_dbg_rdata", 32'(dbg_rdata), 32'h04);
    rst_n = 1'b0;
    #1;
    check("r6_rst_dbg_gnt", 32'(dbg_gnt), 0);
    cyc();
    check("r6_rst_rvalid", 32'(dbg_rvalid), 0);
    check("r6_rst_rdata", 32'(dbg_rdata), 0);
    check("r6_rst_cpu_rdata", 32'(cpu_rdata), 0);
    check("r6_rst_locked", 32'(locked), 0);

    // After reset the CPU wins the first conflict
    rst_n = 1'b1; idle();
    cpu_req = 1'b1; cpu_addr = 8'h07; dbg_req = 1'b1; dbg_addr = 8'h01;
    #1;
    check("post_rst_cpu_gnt", 32'(cpu_gnt), 1);
    check("post_rst_dbg_gnt", 32'(dbg_gnt), 0);
    cyc();
    check("post_rst_rdata", 32'(cpu_rdata), 32'h77);
    idle();
    cyc();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
